// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: prescaled pixel tick, h/v counters, syncs, frame strobe.
// Optional FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic       pix_tick_o,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       valid_o,
    output logic       hsync_o,
    output logic       vsync_o,
`ifdef FRAME_CNT_EN
    output logic [7:0] frame_cnt_o,
`endif
    output logic       frame_start_o
);

    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISP);
    localparam logic [9:0] V_VIS  = 10'(V_DISP);
    localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END = 10'(V_DISP + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             valid_q, valid_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             fs_q, fs_d;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;
`ifdef FRAME_CNT_EN
    logic [7:0]       fc_q, fc_d;
`endif

    always_comb begin
        tick    = en_i && (div_q == DIV_LAST);
        h_wrap  = (h_q == H_LAST);
        v_wrap  = (v_q == V_LAST);
        div_d   = div_q;
        h_d     = h_q;
        v_d     = v_q;
        valid_d = valid_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        fs_d    = 1'b0;
`ifdef FRAME_CNT_EN
        fc_d    = fc_q;
`endif
        if (en_i) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        // Flags are decoded from the next counter values so they stay aligned.
        if (tick) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? 10'd0 : v_q + 10'd1;
            end
            valid_d = (h_d < H_VIS) && (v_d < V_VIS);
            hs_d    = ((h_d >= HS_BEG) && (h_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vs_d    = ((v_d >= VS_BEG) && (v_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
            fs_d    = h_wrap && v_wrap;
`ifdef FRAME_CNT_EN
            if (fs_d) begin
                fc_d = fc_q + 8'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            valid_q <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            fs_q    <= 1'b0;
`ifdef FRAME_CNT_EN
            fc_q    <= '0;
`endif
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            valid_q <= valid_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
`ifdef FRAME_CNT_EN
            fc_q    <= fc_d;
`endif
        end
    end

    assign pix_tick_o    = tick;
    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign valid_o       = valid_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign frame_start_o = fs_q;
`ifdef FRAME_CNT_EN
    assign frame_cnt_o   = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus a tiny fast-frame instance,
// both compared every cycle against a tick-count reference model.
module tb_vga_timing_gen;

    localparam int DV[2]  = '{4, 1};
    localparam int HD[2]  = '{640, 6};
    localparam int HF[2]  = '{16, 2};
    localparam int HSY[2] = '{96, 3};
    localparam int HT[2]  = '{800, 13};
    localparam int VD[2]  = '{480, 4};
    localparam int VF[2]  = '{10, 1};
    localparam int VSY[2] = '{2, 2};
    localparam int VT[2]  = '{525, 8};
    localparam int POL[2] = '{0, 1};

    logic       clk = 1'b0;
    logic       rst_s [2];
    logic       en_s  [2];
    logic       pt    [2];
    logic [9:0] hc    [2];
    logic [9:0] vc    [2];
    logic       val   [2];
    logic       hs    [2];
    logic       vs    [2];
    logic       fs    [2];
`ifdef FRAME_CNT_EN
    logic [7:0] fc    [2];
    int         fc_m  [2];
`endif

    longint ec   [2];
    longint np   [2];
    bit     fs_m [2];
    bit     chk_on = 1'b0;
    bit     rel    = 1'b0;
    bit     b_done = 1'b0;
    int     total  = 0;
    int     bad    = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(4), .H_DISP(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_DISP(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .SYNC_POL(1'b0)
    ) u_a (
        .clk(clk), .rst(rst_s[0]), .en_i(en_s[0]), .pix_tick_o(pt[0]),
        .h_cnt_o(hc[0]), .v_cnt_o(vc[0]), .valid_o(val[0]),
        .hsync_o(hs[0]), .vsync_o(vs[0]),
`ifdef FRAME_CNT_EN
        .frame_cnt_o(fc[0]),
`endif
        .frame_start_o(fs[0])
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISP(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .rst(rst_s[1]), .en_i(en_s[1]), .pix_tick_o(pt[1]),
        .h_cnt_o(hc[1]), .v_cnt_o(vc[1]), .valid_o(val[1]),
        .hsync_o(hs[1]), .vsync_o(vs[1]),
`ifdef FRAME_CNT_EN
        .frame_cnt_o(fc[1]),
`endif
        .frame_start_o(fs[1])
    );

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%0d want=%0d", nm, i, $time, act, exp);
        end
    endtask

    // Reference model: enabled cycles since reset and pixel ticks since reset.
    initial begin
        for (int i = 0; i < 2; i++) begin
            ec[i] = 0; np[i] = 0; fs_m[i] = 0;
`ifdef FRAME_CNT_EN
            fc_m[i] = 0;
`endif
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                fs_m[i] = 0;
                if (rst_s[i]) begin
                    ec[i] = 0; np[i] = 0;
`ifdef FRAME_CNT_EN
                    fc_m[i] = 0;
`endif
                end else if (en_s[i]) begin
                    if (ec[i] % DV[i] == DV[i] - 1) begin
                        np[i]++;
                        fs_m[i] = (np[i] % (HT[i] * VT[i]) == 0);
`ifdef FRAME_CNT_EN
                        if (fs_m[i]) fc_m[i] = (fc_m[i] + 1) % 256;
`endif
                    end
                    ec[i]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int i = 0; i < 2; i++) begin
                    longint p, h, v;
                    bit act;
                    p   = np[i] % (HT[i] * VT[i]);
                    h   = p % HT[i];
                    v   = p / HT[i];
                    act = (np[i] != 0);
                    chk("pix_tick", i, pt[i], en_s[i] && (ec[i] % DV[i] == DV[i] - 1));
                    chk("h_cnt", i, hc[i], h);
                    chk("v_cnt", i, vc[i], v);
                    chk("valid", i, val[i], act && h < HD[i] && v < VD[i]);
                    chk("hsync", i, hs[i],
                        (h >= HD[i] + HF[i] && h < HD[i] + HF[i] + HSY[i]) ? POL[i] : 1 - POL[i]);
                    chk("vsync", i, vs[i],
                        (v >= VD[i] + VF[i] && v < VD[i] + VF[i] + VSY[i]) ? POL[i] : 1 - POL[i]);
                    chk("frame_start", i, fs[i], fs_m[i]);
`ifdef FRAME_CNT_EN
                    chk("frame_cnt", i, fc[i], fc_m[i]);
`endif
                end
            end
        end
    end

    // Second instance: random enable/reset, then full-speed frame checks.
    initial begin
        int nfs, cyc, last, vsc;
        wait (rel);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk); #1;
            en_s[1]  = ($urandom_range(0, 3) != 0);
            rst_s[1] = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk); #1;
        rst_s[1] = 1'b1; en_s[1] = 1'b1;
        @(negedge clk); #1;
        rst_s[1] = 1'b0;
        nfs = 0; cyc = 0; last = 0; vsc = 0;
        while (nfs < 256 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (fs[1]) begin
                nfs++;
                if (nfs == 3) begin
                    chk("frame_period", 1, cyc - last, 104);
                    chk("vsync_ticks", 1, vsc, 26);
`ifdef FRAME_CNT_EN
                    chk("frame_cnt_3", 1, fc[1], 3);
`endif
                end
                last = cyc;
                vsc  = 0;
            end
            if (vs[1]) vsc++;
        end
        chk("frames_seen", 1, nfs, 256);
`ifdef FRAME_CNT_EN
        chk("frame_cnt_256", 1, fc[1], 0);
`endif
        b_done = 1'b1;
    end

    initial begin
        int n, hsl, vcnt;
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;
        en_s[0]  = 1'b1; en_s[1]  = 1'b1;
        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_h", 0, hc[0], 0);
        chk("rst_v", 0, vc[0], 0);
        chk("rst_valid", 0, val[0], 0);
        chk("rst_hsync", 0, hs[0], 1);
        chk("rst_vsync", 0, vs[0], 1);
        chk("rst_fs", 0, fs[0], 0);
        chk("rst_hsync", 1, hs[1], 0);
        @(negedge clk); #1;
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        rel = 1'b1;
        #1;
        chk("tick_rel0", 0, pt[0], 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("tick_rel", k, pt[0], (k == 3) ? 1 : 0);
        end

        n = 0; hsl = 0; vcnt = 0;
        while (vc[0] == 0 && n < 4000) begin
            @(negedge clk);
            n++;
            if (vc[0] == 0) begin
                if (!hs[0]) hsl++;
                if (val[0]) vcnt++;
            end
        end
        chk("line_timeout", 0, (n < 4000) ? 1 : 0, 1);
        chk("hsync_low_clk", 0, hsl, 384);
        chk("valid_clk", 0, vcnt, 2556);
        chk("wrap_h", 0, hc[0], 0);
        chk("wrap_v", 0, vc[0], 1);

        n = 0;
        while (hc[0] != 300 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("h300_timeout", 0, (n < 2000) ? 1 : 0, 1);
        #1 en_s[0] = 1'b0;
        repeat (50) @(negedge clk);
        chk("freeze_h", 0, hc[0], 300);
        chk("freeze_tick", 0, pt[0], 0);
        #1 en_s[0] = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (hc[0] != 301 && n < 20);
        chk("resume_edges", 0, n, 4);

        n = 0;
        while (hc[0] != 400 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #1 rst_s[0] = 1'b1;
        @(negedge clk);
        chk("mrst_h", 0, hc[0], 0);
        chk("mrst_v", 0, vc[0], 0);
        chk("mrst_valid", 0, val[0], 0);
        chk("mrst_hsync", 0, hs[0], 1);
        chk("mrst_fs", 0, fs[0], 0);
        #1 rst_s[0] = 1'b0;

        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            en_s[0]  = ($urandom_range(0, 4) != 0);
            rst_s[0] = ($urandom_range(0, 499) == 0);
        end
        rst_s[0] = 1'b0;
        en_s[0]  = 1'b1;

        n = 0;
        while (!b_done && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("b_timeout", 1, b_done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
